// File: rtl/mux_ser_pkg.sv
// Shared definitions for the bit-select serializer and its downstream mux stages.
package mux_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a select bus addressing 'width' bit positions (at least one bit).
  function automatic int unsigned sel_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mux_ser_if.sv
// Word-in / bit-out handshake bundle for mux_serializer.
interface mux_ser_if
  import mux_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  localparam int unsigned CW = sel_width(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_out;
  logic [CW-1:0]    sel;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  in_valid, in_data, ser_ready,
    output in_ready, ser_valid, ser_out, sel, ser_last, busy
  );

  modport master (
    output in_valid, in_data, ser_ready,
    input  in_ready, ser_valid, ser_out, sel, ser_last, busy
  );

endinterface

// File: rtl/mux_serializer_bit_select_mux.sv
// Combinational WIDTH:1 bit selector; out-of-range select values yield 0.
module bit_select_mux
  import mux_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = sel_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    sel,
  output logic             y
);

  always_comb begin
    y = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sel == CW'(i)) y = data[i];
    end
  end

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end: accepts a word, then presents one selected bit
// per cycle together with the select index driving a downstream mux.
module mux_serializer
  import mux_ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mux_ser_if.slave  bus
);

  localparam int unsigned   CW   = sel_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic [CW-1:0]    w_sel;
  logic             w_ser_out;

  assign w_shift = (r_state == SHIFT);
  assign w_last  = w_shift && (r_count == LAST);
  // sel is held at 0 outside SHIFT so MSB-first builds also idle at 0.
  assign w_sel   = !w_shift ? '0 : (LSB_FIRST ? r_count : LAST - r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = SHIFT;
          w_count_nxt = '0;
          w_load      = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          if (w_last) begin
            w_count_nxt = '0;
            if (bus.in_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_load) r_word <= bus.in_data;
    end
  end

  bit_select_mux #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_select_mux (
    .data (r_word),
    .sel  (w_sel),
    .y    (w_ser_out)
  );

  assign bus.in_ready  = !rst && (!w_shift || (w_last && bus.ser_ready));
  assign bus.ser_valid = w_shift;
  assign bus.ser_out   = w_ser_out;
  assign bus.sel       = w_sel;
  assign bus.ser_last  = w_last;
  assign bus.busy      = w_shift;

endmodule

// File: tb/tb_mux_serializer.sv
// Three serializer configurations checked cycle by cycle against a queue-of-bits model.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_ser_if #(.WIDTH(8)) ifa ();
  mux_ser_if #(.WIDTH(8)) ifb ();
  mux_ser_if #(.WIDTH(3)) ifc ();

  mux_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mux_serializer #(.WIDTH(3), .LSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic        b;
    int unsigned s;
    logic        l;
  } beat_t;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int unsigned W    [3] = '{8, 8, 3};
  bit          LSBF [3] = '{1'b1, 1'b0, 1'b1};

  beat_t       q    [3][$];
  logic        iv   [3];
  logic        rdy  [3];
  logic [63:0] dat  [3];
  logic        rst_req;

  logic [63:0] o_ir [3], o_v [3], o_out [3], o_sel [3], o_last [3], o_busy [3];

  task automatic check(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %0h, expected %0h", tag, k, obs, exp);
    end
  endtask

  // Expected bit stream of one accepted word, in presentation order.
  function automatic void push(input int k, input logic [63:0] w);
    beat_t b;
    for (int unsigned i = 0; i < W[k]; i++) begin
      b.s = LSBF[k] ? i : W[k] - 1 - i;
      b.b = w[b.s];
      b.l = (i == W[k] - 1);
      q[k].push_back(b);
    end
  endfunction

  task automatic step();
    logic exp_ir;
    logic acc;
    @(negedge clk);
    rst           = rst_req;
    ifa.in_valid  = iv[0]; ifa.in_data = dat[0][7:0]; ifa.ser_ready = rdy[0];
    ifb.in_valid  = iv[1]; ifb.in_data = dat[1][7:0]; ifb.ser_ready = rdy[1];
    ifc.in_valid  = iv[2]; ifc.in_data = dat[2][2:0]; ifc.ser_ready = rdy[2];
    #1;
    o_ir[0] = 64'(ifa.in_ready); o_v[0] = 64'(ifa.ser_valid); o_out[0] = 64'(ifa.ser_out);
    o_sel[0] = 64'(ifa.sel); o_last[0] = 64'(ifa.ser_last); o_busy[0] = 64'(ifa.busy);
    o_ir[1] = 64'(ifb.in_ready); o_v[1] = 64'(ifb.ser_valid); o_out[1] = 64'(ifb.ser_out);
    o_sel[1] = 64'(ifb.sel); o_last[1] = 64'(ifb.ser_last); o_busy[1] = 64'(ifb.busy);
    o_ir[2] = 64'(ifc.in_ready); o_v[2] = 64'(ifc.ser_valid); o_out[2] = 64'(ifc.ser_out);
    o_sel[2] = 64'(ifc.sel); o_last[2] = 64'(ifc.ser_last); o_busy[2] = 64'(ifc.busy);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        check("rst_in_ready", k, o_ir[k], 64'd0);
        check("rst_ser_valid", k, o_v[k], 64'd0);
        check("rst_sel", k, o_sel[k], 64'd0);
        check("rst_ser_out", k, o_out[k], 64'd0);
        check("rst_ser_last", k, o_last[k], 64'd0);
        check("rst_busy", k, o_busy[k], 64'd0);
        q[k].delete();
      end else begin
        exp_ir = (q[k].size() == 0) || (q[k].size() == 1 && rdy[k]);
        check("in_ready", k, o_ir[k], 64'(exp_ir));
        check("ser_valid", k, o_v[k], 64'(q[k].size() != 0));
        check("busy", k, o_busy[k], 64'(q[k].size() != 0));
        if (q[k].size() != 0) begin
          check("ser_out", k, o_out[k], 64'(q[k][0].b));
          check("sel", k, o_sel[k], 64'(q[k][0].s));
          check("ser_last", k, o_last[k], 64'(q[k][0].l));
        end else begin
          check("idle_ser_last", k, o_last[k], 64'd0);
        end
        acc = iv[k] && exp_ir;
        if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
        if (acc) push(k, dat[k] & ((64'd1 << W[k]) - 64'd1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; rdy[k] = 1'b1; dat[k] = '0;
    end
    step(); step();
    rst_req = 1'b0;
    step();

    // A: single 8'hA5; B: MSB-first 8'h80; C: width-3 back-to-back 110, 011
    iv[0] = 1'b1; dat[0] = 64'hA5;
    iv[1] = 1'b1; dat[1] = 64'h80;
    iv[2] = 1'b1; dat[2] = 64'h6;
    step();
    iv[0] = 1'b0; iv[1] = 1'b0; dat[2] = 64'h3;
    repeat (3) step();
    iv[2] = 1'b0;
    repeat (8) step();

    // A: back-to-back 8'hA5 then 8'h3C with in_valid held
    iv[0] = 1'b1; dat[0] = 64'hA5;
    step();
    dat[0] = 64'h3C;
    repeat (8) step();
    iv[0] = 1'b0;
    repeat (10) step();

    // A: stall three cycles on sel = 3; in_data changes after accept
    iv[0] = 1'b1; dat[0] = 64'hA5;
    step();
    iv[0] = 1'b0; dat[0] = 64'hFF;
    repeat (3) step();
    rdy[0] = 1'b0;
    repeat (3) step();
    rdy[0] = 1'b1;
    repeat (7) step();

    // A: reset during the 4th bit, then no stale bits
    iv[0] = 1'b1; dat[0] = 64'hA5;
    step();
    iv[0] = 1'b0;
    repeat (3) step();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    repeat (4) step();

    // Randomized traffic on all three instances
    repeat (400) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]  = ($urandom_range(0, 2) != 0);
        rdy[k] = ($urandom_range(0, 3) != 0);
        dat[k] = {$urandom, $urandom};
      end
      rst_req = ($urandom_range(0, 149) == 0);
      step();
    end
    rst_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; rdy[k] = 1'b1;
    end
    repeat (12) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
